macc_arbiter: RTL and testbench

Round-robin arbiter that shares one multiply-accumulate datapath between NCH requesting channels. Each requester offers an (a, b) operand pair on its own stream. The arbiter grants one requester at a time and issues that pair on the datapath's separate a/b operand streams. It tags each issued pair with the requester ID in an in-order ID FIFO, and returns each datapath result to the requester that issued the matching pair.

---
 rtl/macc_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_macc_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/macc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : macc_arbiter
// Purpose  : Round-robin arbiter sharing one multiply-accumulate datapath
//            between NCH requesters. A granted (a, b) pair is held and issued
//            on independent a/b operand streams. The requester ID is queued in
//            an in-order ID FIFO, and each result is routed back to the
//            requester at the FIFO head.
// Ports    : clk, rst                 - clock, async active-high reset
//            s_axis_tdata_a/_b/tvalid - per-requester operand pairs (in)
//            s_axis_tready            - per-requester accept, one-hot or zero
//            m_axis_a*/m_axis_b*      - operand streams to the datapath
//            s_axis_rt*               - result stream from the datapath
//            m_axis_tdata/tvalid/tready - result stream back to requesters
//            err_orphan               - sticky: result seen with no pair
//                                       outstanding
// Revision : 1.0 - initial release
// ============================================================================
module macc_arbiter #(
    parameter  int NCH   = 4,
    parameter  int DW    = 24,
    parameter  int COEFW = 18,
    parameter  int DEPTH = 8,
    localparam int MW    = DW + COEFW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*DW-1:0]    s_axis_tdata_a,
    input  logic [NCH*COEFW-1:0] s_axis_tdata_b,
    input  logic [NCH-1:0]       s_axis_tvalid,
    output logic [NCH-1:0]       s_axis_tready,
    output logic [DW-1:0]        m_axis_atdata,
    output logic                 m_axis_atvalid,
    input  logic                 m_axis_atready,
    output logic [COEFW-1:0]     m_axis_btdata,
    output logic                 m_axis_btvalid,
    input  logic                 m_axis_btready,
    input  logic [MW-1:0]        s_axis_rtdata,
    input  logic                 s_axis_rtvalid,
    output logic                 s_axis_rtready,
    output logic [MW-1:0]        m_axis_tdata,
    output logic [NCH-1:0]       m_axis_tvalid,
    input  logic [NCH-1:0]       m_axis_tready,
    output logic                 err_orphan
);

    localparam int IW = $clog2(NCH);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_ISSUE = 1'b1;

    logic [0:0]       r_state;
    logic [DW-1:0]    r_a_hold;
    logic [COEFW-1:0] r_b_hold;
    logic             r_a_done;
    logic             r_b_done;
    logic [IW-1:0]    r_last_grant;
    logic [IW-1:0]    r_fifo [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_err_orphan;

    logic [DW-1:0]    w_a_ch [NCH];
    logic [COEFW-1:0] w_b_ch [NCH];
    logic [IW-1:0]    w_scan_idx;
    logic [IW-1:0]    w_grant_idx;
    logic             w_any;
    logic             w_grant;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_a_hs;
    logic             w_b_hs;
    logic [IW-1:0]    w_head;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_split
            assign w_a_ch[i] = s_axis_tdata_a[i*DW +: DW];
            assign w_b_ch[i] = s_axis_tdata_b[i*COEFW +: COEFW];
        end
    endgenerate

    // Round-robin search: walk from last_grant+1 with wrap, first valid wins.
    always_comb begin
        w_scan_idx  = r_last_grant;
        w_grant_idx = r_last_grant;
        w_any       = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            w_scan_idx = (w_scan_idx == IW'(NCH - 1)) ? '0 : w_scan_idx + 1'b1;
            if (!w_any && s_axis_tvalid[w_scan_idx]) begin
                w_any       = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
    end

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Gated by rst so that the combinational accept path is quiet while reset
    // is held, even if requesters keep tvalid high.
    assign w_grant       = (r_state == c_IDLE) && !w_full && w_any && !rst;
    assign s_axis_tready = w_grant ? (NCH'(1) << w_grant_idx) : '0;

    assign m_axis_atdata  = r_a_hold;
    assign m_axis_btdata  = r_b_hold;
    assign m_axis_atvalid = (r_state == c_ISSUE) && !r_a_done;
    assign m_axis_btvalid = (r_state == c_ISSUE) && !r_b_done;
    assign w_a_hs         = m_axis_atvalid && m_axis_atready;
    assign w_b_hs         = m_axis_btvalid && m_axis_btready;

    // Result return is purely combinational; the head ID steers the result.
    assign w_head         = r_fifo[r_rd_ptr];
    assign m_axis_tdata   = s_axis_rtdata;
    assign m_axis_tvalid  = (s_axis_rtvalid && !w_empty) ? (NCH'(1) << w_head) : '0;
    assign s_axis_rtready = !w_empty && m_axis_tready[w_head];
    assign w_pop          = s_axis_rtvalid && s_axis_rtready;
    assign err_orphan     = r_err_orphan;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_a_hold     <= '0;
            r_b_hold     <= '0;
            r_a_done     <= 1'b0;
            r_b_done     <= 1'b0;
            r_last_grant <= IW'(NCH - 1);
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_grant) begin
                        r_a_hold     <= w_a_ch[w_grant_idx];
                        r_b_hold     <= w_b_ch[w_grant_idx];
                        r_last_grant <= w_grant_idx;
                        r_a_done     <= 1'b0;
                        r_b_done     <= 1'b0;
                        r_state      <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    r_a_done <= r_a_done | w_a_hs;
                    r_b_done <= r_b_done | w_b_hs;
                    if ((r_a_done || w_a_hs) && (r_b_done || w_b_hs)) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_grant) begin
                r_fifo[r_wr_ptr] <= w_grant_idx;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A result with nothing outstanding is stalled (rtready stays low) and
    // flagged; only reset clears the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_orphan <= 1'b0;
        end else if (s_axis_rtvalid && w_empty) begin
            r_err_orphan <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_macc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_macc_arbiter
// Purpose  : Directed self-checking bench for macc_arbiter (NCH=4, DW=24,
//            COEFW=18, DEPTH=8). The bench drives the datapath side directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_macc_arbiter;

    localparam int NCH   = 4;
    localparam int DW    = 24;
    localparam int COEFW = 18;
    localparam int DEPTH = 8;
    localparam int MW    = DW + COEFW;

    logic                 clk;
    logic                 rst;
    logic [NCH*DW-1:0]    s_axis_tdata_a;
    logic [NCH*COEFW-1:0] s_axis_tdata_b;
    logic [NCH-1:0]       s_axis_tvalid;
    logic [NCH-1:0]       s_axis_tready;
    logic [DW-1:0]        m_axis_atdata;
    logic                 m_axis_atvalid;
    logic                 m_axis_atready;
    logic [COEFW-1:0]     m_axis_btdata;
    logic                 m_axis_btvalid;
    logic                 m_axis_btready;
    logic [MW-1:0]        s_axis_rtdata;
    logic                 s_axis_rtvalid;
    logic                 s_axis_rtready;
    logic [MW-1:0]        m_axis_tdata;
    logic [NCH-1:0]       m_axis_tvalid;
    logic [NCH-1:0]       m_axis_tready;
    logic                 err_orphan;

    int n_checks = 0;
    int n_errors = 0;

    macc_arbiter #(
        .NCH   (NCH),
        .DW    (DW),
        .COEFW (COEFW),
        .DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata_a (s_axis_tdata_a),
        .s_axis_tdata_b (s_axis_tdata_b),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .m_axis_atdata  (m_axis_atdata),
        .m_axis_atvalid (m_axis_atvalid),
        .m_axis_atready (m_axis_atready),
        .m_axis_btdata  (m_axis_btdata),
        .m_axis_btvalid (m_axis_btvalid),
        .m_axis_btready (m_axis_btready),
        .s_axis_rtdata  (s_axis_rtdata),
        .s_axis_rtvalid (s_axis_rtvalid),
        .s_axis_rtready (s_axis_rtready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .err_orphan     (err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] za(input int v);
        logic [DW-1:0] t;
        t = DW'(v);
        return {{(64-DW){1'b0}}, t};
    endfunction

    function automatic logic [63:0] zb(input int v);
        logic [COEFW-1:0] t;
        t = COEFW'(v);
        return {{(64-COEFW){1'b0}}, t};
    endfunction

    function automatic logic [63:0] zr(input int v);
        logic [MW-1:0] t;
        t = MW'(v);
        return {{(64-MW){1'b0}}, t};
    endfunction

    function automatic logic [63:0] oh(input int ch);
        return 64'(1) << ch;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pair(input int ch, input int a, input int b);
        s_axis_tdata_a[ch*DW +: DW]       = DW'(a);
        s_axis_tdata_b[ch*COEFW +: COEFW] = COEFW'(b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        s_axis_tdata_a = '0;
        s_axis_tdata_b = '0;
        s_axis_tvalid  = '0;
        m_axis_atready = 1'b0;
        m_axis_btready = 1'b0;
        s_axis_rtdata  = '0;
        s_axis_rtvalid = 1'b0;
        m_axis_tready  = '0;
        #1;
        chk("rst_tready",  64'(s_axis_tready),  64'(0));
        chk("rst_atvalid", 64'(m_axis_atvalid), 64'(0));
        chk("rst_btvalid", 64'(m_axis_btvalid), 64'(0));
        chk("rst_rtready", 64'(s_axis_rtready), 64'(0));
        chk("rst_tvalid",  64'(m_axis_tvalid),  64'(0));
        chk("rst_err",     64'(err_orphan),     64'(0));
        chk("rst_atdata",  64'(m_axis_atdata),  64'(0));
        chk("rst_btdata",  64'(m_axis_btdata),  64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // ---- single pair from ch2 ----
        set_pair(2, -3, 5);
        s_axis_tvalid  = 4'b0100;
        m_axis_atready = 1'b1;
        m_axis_btready = 1'b1;
        #1;
        chk("single_grant", 64'(s_axis_tready), 64'(4'b0100));
        tick();
        s_axis_tvalid = '0;
        #1;
        chk("single_atvalid", 64'(m_axis_atvalid), 64'(1));
        chk("single_btvalid", 64'(m_axis_btvalid), 64'(1));
        chk("single_atdata",  64'(m_axis_atdata),  za(-3));
        chk("single_btdata",  64'(m_axis_btdata),  zb(5));
        chk("single_nogrant", 64'(s_axis_tready),  64'(0));
        tick();
        #1;
        chk("single_idle_atvalid", 64'(m_axis_atvalid), 64'(0));
        s_axis_rtvalid = 1'b1;
        s_axis_rtdata  = MW'(-15);
        m_axis_tready  = 4'hF;
        #1;
        chk("single_tvalid",  64'(m_axis_tvalid),  64'(4'b0100));
        chk("single_tdata",   64'(m_axis_tdata),   zr(-15));
        chk("single_rtready", 64'(s_axis_rtready), 64'(1));
        tick();
        s_axis_rtvalid = 1'b0;
        #1;
        chk("single_empty", 64'(s_axis_rtready), 64'(0));

        // ---- fairness: all channels valid ----
        do_reset();
        for (int i = 0; i < NCH; i++) set_pair(i, 10 + i, -(i + 1));
        s_axis_tvalid = 4'hF;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("fair_grant%0d", k), 64'(s_axis_tready), oh(k % NCH));
            tick();
            if (k == 5) s_axis_tvalid = '0;
            #1;
            chk($sformatf("fair_atdata%0d", k), 64'(m_axis_atdata), za(10 + k % NCH));
            chk($sformatf("fair_btdata%0d", k), 64'(m_axis_btdata), zb(-(k % NCH + 1)));
            tick();
            #1;
        end
        for (int k = 0; k < 6; k++) begin
            s_axis_rtvalid = 1'b1;
            s_axis_rtdata  = MW'((10 + k % NCH) * (-(k % NCH + 1)));
            #1;
            chk($sformatf("fair_route%0d", k), 64'(m_axis_tvalid), oh(k % NCH));
            chk($sformatf("fair_tdata%0d", k), 64'(m_axis_tdata), zr((10 + k % NCH) * (-(k % NCH + 1))));
            tick();
        end
        s_axis_rtvalid = 1'b0;

        // ---- split operand handshake on ch3 (last grant was ch1) ----
        set_pair(3, 100, -7);
        s_axis_tvalid  = 4'b1000;
        m_axis_atready = 1'b1;
        m_axis_btready = 1'b0;
        #1;
        chk("split_grant", 64'(s_axis_tready), 64'(4'b1000));
        tick();
        s_axis_tvalid = 4'b0001;
        #1;
        chk("split_c1_atvalid", 64'(m_axis_atvalid), 64'(1));
        chk("split_c1_btvalid", 64'(m_axis_btvalid), 64'(1));
        chk("split_c1_nogrant", 64'(s_axis_tready),  64'(0));
        tick();
        #1;
        chk("split_c2_atvalid", 64'(m_axis_atvalid), 64'(0));
        chk("split_c2_btvalid", 64'(m_axis_btvalid), 64'(1));
        chk("split_c2_btdata",  64'(m_axis_btdata),  zb(-7));
        chk("split_c2_nogrant", 64'(s_axis_tready),  64'(0));
        tick();
        #1;
        chk("split_c3_atvalid", 64'(m_axis_atvalid), 64'(0));
        chk("split_c3_btdata",  64'(m_axis_btdata),  zb(-7));
        tick();
        m_axis_btready = 1'b1;
        #1;
        chk("split_c4_btvalid", 64'(m_axis_btvalid), 64'(1));
        chk("split_c4_nogrant", 64'(s_axis_tready),  64'(0));
        tick();
        #1;
        chk("split_c5_atvalid", 64'(m_axis_atvalid), 64'(0));
        chk("split_c5_grant0",  64'(s_axis_tready),  64'(4'b0001));
        tick();
        s_axis_tvalid = '0;
        #1;
        tick();
        #1;
        s_axis_rtvalid = 1'b1;
        s_axis_rtdata  = MW'(-700);
        #1;
        chk("split_ret_ch3", 64'(m_axis_tvalid), 64'(4'b1000));
        tick();
        #1;
        chk("split_ret_ch0", 64'(m_axis_tvalid), 64'(4'b0001));
        tick();
        s_axis_rtvalid = 1'b0;

        // ---- FIFO full ----
        do_reset();
        s_axis_tvalid = 4'hF;
        #1;
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("full_grant%0d", k), 64'(s_axis_tready), oh(k % NCH));
            tick();
            #1;
            tick();
            #1;
        end
        chk("full_blocked", 64'(s_axis_tready), 64'(0));
        tick();
        #1;
        chk("full_blocked2", 64'(s_axis_tready), 64'(0));
        s_axis_rtvalid = 1'b1;
        s_axis_rtdata  = MW'(123);
        m_axis_tready  = 4'hF;
        #1;
        chk("full_pop_rtready", 64'(s_axis_rtready), 64'(1));
        chk("full_pop_tvalid",  64'(m_axis_tvalid),  64'(4'b0001));
        chk("full_pop_nograntsame", 64'(s_axis_tready), 64'(0));
        tick();
        s_axis_rtvalid = 1'b0;
        #1;
        chk("full_regrant", 64'(s_axis_tready), 64'(4'b0001));
        tick();
        s_axis_tvalid = '0;
        #1;
        tick();
        #1;

        // ---- result backpressure: FIFO holds 1,2,3,0,1,2,3,0 ----
        s_axis_rtvalid = 1'b1;
        m_axis_tready  = 4'b1101;
        #1;
        chk("bp_rtready", 64'(s_axis_rtready), 64'(0));
        chk("bp_tvalid",  64'(m_axis_tvalid),  64'(4'b0010));
        tick();
        #1;
        chk("bp_nopop",    64'(m_axis_tvalid),  64'(4'b0010));
        chk("bp_rtready2", 64'(s_axis_rtready), 64'(0));
        m_axis_tready = 4'b0010;
        #1;
        chk("bp_release", 64'(s_axis_rtready), 64'(1));
        tick();
        #1;
        chk("bp_next_head", 64'(m_axis_tvalid),  64'(4'b0100));
        chk("bp_next_stall", 64'(s_axis_rtready), 64'(0));
        m_axis_tready = 4'hF;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk($sformatf("bp_drain%0d", k), 64'(m_axis_tvalid), oh((k + 2) % NCH));
            tick();
        end
        s_axis_rtvalid = 1'b0;
        #1;
        chk("bp_empty", 64'(s_axis_rtready), 64'(0));

        // ---- orphan result, then reset during ISSUE ----
        s_axis_rtvalid = 1'b1;
        #1;
        chk("orph_rtready",  64'(s_axis_rtready), 64'(0));
        chk("orph_tvalid",   64'(m_axis_tvalid),  64'(0));
        chk("orph_err_pre",  64'(err_orphan),     64'(0));
        tick();
        #1;
        chk("orph_err",      64'(err_orphan),     64'(1));
        chk("orph_stall",    64'(s_axis_rtready), 64'(0));
        s_axis_rtvalid = 1'b0;
        set_pair(2, 55, 66);
        s_axis_tvalid  = 4'b0101;
        m_axis_btready = 1'b0;
        #1;
        chk("orph_grant2", 64'(s_axis_tready), 64'(4'b0100));
        tick();
        #1;
        chk("orph_issue", 64'(m_axis_atvalid), 64'(1));
        rst = 1'b1;
        #1;
        chk("arst_tready",  64'(s_axis_tready),  64'(0));
        chk("arst_atvalid", 64'(m_axis_atvalid), 64'(0));
        chk("arst_btvalid", 64'(m_axis_btvalid), 64'(0));
        chk("arst_rtready", 64'(s_axis_rtready), 64'(0));
        chk("arst_tvalid",  64'(m_axis_tvalid),  64'(0));
        chk("arst_err",     64'(err_orphan),     64'(0));
        chk("arst_atdata",  64'(m_axis_atdata),  64'(0));
        chk("arst_btdata",  64'(m_axis_btdata),  64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_ch0_first", 64'(s_axis_tready), 64'(4'b0001));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
